// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder_pkg
//  Brief    : Load/store size codes, responder state encodings and helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package data_mem_responder_pkg;

    localparam logic [1:0] MEM_BS_NONE = 2'b00;
    localparam logic [1:0] MEM_BS_BYTE = 2'b01;
    localparam logic [1:0] MEM_BS_HALF = 2'b10;
    localparam logic [1:0] MEM_BS_WORD = 2'b11;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_issue = 3'd1;
    localparam logic [2:0] c_st_drain = 3'd2;
    localparam logic [2:0] c_st_resp  = 3'd3;
    localparam logic [2:0] c_st_err   = 3'd4;

    // Index of the final byte beat for a given access size.
    function automatic logic [1:0] beat_last(input logic [1:0] bs);
        case (bs)
            MEM_BS_HALF: beat_last = 2'd1;
            MEM_BS_WORD: beat_last = 2'd3;
            default:     beat_last = 2'd0;
        endcase
    endfunction

    function automatic logic access_err(input logic [1:0] bs, input logic [1:0] addr_lo);
        case (bs)
            MEM_BS_NONE: access_err = 1'b1;
            MEM_BS_HALF: access_err = addr_lo[0];
            MEM_BS_WORD: access_err = (addr_lo != 2'b00);
            default:     access_err = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_load_extend.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder_load_extend
//  Brief    : Sign/zero extension of an assembled little-endian load word.
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder_load_extend
    import data_mem_responder_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_mem_bs,
    input  logic        i_mem_se,
    output logic [31:0] o_rdata
);

    always_comb begin
        o_rdata = i_word;
        case (i_mem_bs)
            MEM_BS_BYTE: o_rdata = {{24{i_mem_se & i_word[7]}},  i_word[7:0]};
            MEM_BS_HALF: o_rdata = {{16{i_mem_se & i_word[15]}}, i_word[15:0]};
            default:     o_rdata = i_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder
//  Brief    : Byte-serial load/store responder for a byte-wide synchronous RAM.
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              mem_we,
    input  logic              mem_se,
    input  logic [1:0]        mem_bs,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    logic [2:0]        r_state;
    logic              r_we;
    logic              r_se;
    logic [1:0]        r_bs;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [1:0]        r_beat;
    logic [31:0]       r_asm;

    logic              r_req_ready;
    logic              r_done;
    logic              r_err;
    logic [31:0]       r_rdata;
    logic              r_ram_en;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [7:0]        r_ram_wdata;

    logic [1:0]        w_next_beat;
    logic [1:0]        w_prev_beat;
    logic [31:0]       w_assembled;
    logic [31:0]       w_extended;

    assign w_next_beat = r_beat + 2'd1;
    assign w_prev_beat = r_beat - 2'd1;

    // The final byte arrives during DRAIN, so merge it straight from the RAM.
    always_comb begin
        w_assembled = r_asm;
        w_assembled[{r_beat, 3'b000} +: 8] = ram_rdata;
    end

    data_mem_responder_load_extend u_load_extend (
        .i_word   (w_assembled),
        .i_mem_bs (r_bs),
        .i_mem_se (r_se),
        .o_rdata  (w_extended)
    );

    generate
        if (ADDR_W < 32) begin : g_addr_upper
            logic w_unused_addr;
            assign w_unused_addr = ^addr[31:ADDR_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_we        <= 1'b0;
            r_se        <= 1'b0;
            r_bs        <= MEM_BS_NONE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_beat      <= 2'd0;
            r_asm       <= '0;
            r_req_ready <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (req_valid) begin
                        r_we        <= mem_we;
                        r_se        <= mem_se;
                        r_bs        <= mem_bs;
                        r_addr      <= addr[ADDR_W-1:0];
                        r_wdata     <= wdata;
                        r_beat      <= 2'd0;
                        r_asm       <= '0;
                        r_req_ready <= 1'b0;
                        if (access_err(mem_bs, addr[1:0])) begin
                            r_state <= c_st_err;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state     <= c_st_issue;
                            r_ram_en    <= 1'b1;
                            r_ram_we    <= mem_we;
                            r_ram_addr  <= addr[ADDR_W-1:0];
                            r_ram_wdata <= wdata[7:0];
                        end
                    end
                end
                c_st_issue: begin
                    // Read data for beat k is on ram_rdata while beat k+1 is issued.
                    if (!r_we && (r_beat != 2'd0)) begin
                        r_asm[{w_prev_beat, 3'b000} +: 8] <= ram_rdata;
                    end
                    if (r_beat == beat_last(r_bs)) begin
                        r_ram_en <= 1'b0;
                        r_ram_we <= 1'b0;
                        if (r_we) begin
                            r_state <= c_st_resp;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= c_st_drain;
                        end
                    end else begin
                        r_beat      <= w_next_beat;
                        r_ram_addr  <= r_addr + ADDR_W'(w_next_beat);
                        r_ram_wdata <= r_wdata[{w_next_beat, 3'b000} +: 8];
                    end
                end
                c_st_drain: begin
                    r_rdata <= w_extended;
                    r_done  <= 1'b1;
                    r_state <= c_st_resp;
                end
                c_st_resp, c_st_err: begin
                    r_done      <= 1'b0;
                    r_err       <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= c_st_idle;
                end
                default: begin
                    r_state     <= c_st_idle;
                    r_done      <= 1'b0;
                    r_err       <= 1'b0;
                    r_ram_en    <= 1'b0;
                    r_ram_we    <= 1'b0;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign done      = r_done;
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_responder
//  Brief    : Directed, table-driven bench for data_mem_responder with RAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              mem_we;
    logic              mem_se;
    logic [1:0]        mem_bs;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              done;
    logic              err;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .mem_we    (mem_we),
        .mem_se    (mem_se),
        .mem_bs    (mem_bs),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .done      (done),
        .err       (err),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Byte-wide RAM with one-cycle read latency
    logic [7:0] tbmem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) tbmem[ram_addr] <= ram_wdata;
            else        ram_rdata <= tbmem[ram_addr];
        end
    end

    typedef struct {
        int         cyc;
        logic [11:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t wlog[$];
    int  en_cnt   = 0;
    int  done_cnt = 0;
    time t_acc    = 0;

    always @(negedge clk) begin
        wr_t e;
        if (ram_en) begin
            en_cnt++;
            if (ram_we) begin
                e.cyc = int'(($time - t_acc) / 10);
                e.a   = ram_addr;
                e.d   = ram_wdata;
                wlog.push_back(e);
            end
        end
        if (done) done_cnt++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int beats(input logic [1:0] bs);
        case (bs)
            2'b01:   return 1;
            2'b10:   return 2;
            2'b11:   return 4;
            default: return 0;
        endcase
    endfunction

    // Issue one request from a negedge; returns at the negedge of the done cycle.
    task automatic do_req(input logic we, input logic se, input logic [1:0] bs,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic e_o, output logic [31:0] rd,
                          output logic rdy_done);
        int guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("ready_timeout", 32'(guard), 32'd0);
        req_valid = 1'b1;
        mem_we    = we;
        mem_se    = se;
        mem_bs    = bs;
        addr      = a;
        wdata     = wd;
        t_acc     = $time;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat      = -1;
        e_o      = 1'bx;
        rd       = 'x;
        rdy_done = 1'bx;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done) begin
                lat      = c;
                e_o      = err;
                rd       = rdata;
                rdy_done = req_ready;
                break;
            end
        end
    endtask

    typedef struct {
        logic        we;
        logic        se;
        logic [1:0]  bs;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input logic se, input logic [1:0] bs,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] exp_rd, input logic exp_e, input int exp_l);
        vec_t v;
        v.we = we; v.se = se; v.bs = bs; v.addr = a; v.wdata = wd;
        v.exp_rdata = exp_rd; v.exp_err = exp_e; v.exp_lat = exp_l;
        return v;
    endfunction

    initial begin
        int          lat;
        logic        e_o;
        logic        rdy;
        logic [31:0] rd;
        logic [31:0] hold;
        logic [31:0] exp_rd;
        logic [31:0] tmp;
        logic [11:0] ea;
        logic [7:0]  done_bits;
        logic [7:0]  rdy_bits;
        int          wbase;
        int          ebase;
        int          dbase;
        int          n;
        vec_t        v;

        //          we    se    bs     addr          wdata         exp_rdata     err   lat
        vecs.push_back(mk(1'b1, 1'b0, 2'b11, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        1'b0, 5));
        vecs.push_back(mk(1'b0, 1'b0, 2'b11, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 1'b0, 6));
        vecs.push_back(mk(1'b1, 1'b0, 2'b01, 32'h0000_0101, 32'h1234_5680, 32'h0,        1'b0, 2));
        vecs.push_back(mk(1'b0, 1'b1, 2'b01, 32'h0000_0101, 32'h0,         32'hFFFF_FF80, 1'b0, 3));
        vecs.push_back(mk(1'b0, 1'b0, 2'b01, 32'h0000_0101, 32'h0,         32'h0000_0080, 1'b0, 3));
        vecs.push_back(mk(1'b1, 1'b0, 2'b10, 32'h0000_0202, 32'hABCD_9234, 32'h0,        1'b0, 3));
        vecs.push_back(mk(1'b0, 1'b1, 2'b10, 32'h0000_0202, 32'h0,         32'hFFFF_9234, 1'b0, 4));
        vecs.push_back(mk(1'b0, 1'b0, 2'b10, 32'h0000_0202, 32'h0,         32'h0000_9234, 1'b0, 4));
        vecs.push_back(mk(1'b0, 1'b1, 2'b10, 32'h0000_0203, 32'h0,         32'h0,        1'b1, 1));
        vecs.push_back(mk(1'b0, 1'b0, 2'b11, 32'h0000_0102, 32'h0,         32'h0,        1'b1, 1));
        vecs.push_back(mk(1'b1, 1'b0, 2'b00, 32'h0000_0100, 32'h5555_5555, 32'h0,        1'b1, 1));
        vecs.push_back(mk(1'b1, 1'b0, 2'b11, 32'h0000_0FFC, 32'hCAFE_F00D, 32'h0,        1'b0, 5));
        vecs.push_back(mk(1'b0, 1'b1, 2'b11, 32'h0000_3FFC, 32'h0,         32'hCAFE_F00D, 1'b0, 6));
        vecs.push_back(mk(1'b0, 1'b0, 2'b01, 32'h0000_1103, 32'h0,         32'h0000_00DE, 1'b0, 3));
        vecs.push_back(mk(1'b0, 1'b1, 2'b01, 32'hF000_0100, 32'h0,         32'hFFFF_FFEF, 1'b0, 3));
        vecs.push_back(mk(1'b1, 1'b1, 2'b01, 32'h0000_0042, 32'h0000_00AA, 32'h0,        1'b0, 2));
        vecs.push_back(mk(1'b1, 1'b0, 2'b01, 32'h0000_0043, 32'h0000_00BB, 32'h0,        1'b0, 2));

        rst = 1'b1; req_valid = 1'b0; mem_we = 1'b0; mem_se = 1'b0;
        mem_bs = 2'b00; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_done",      32'(done),      32'd0);
        chk("reset_err",       32'(err),       32'd0);
        chk("reset_rdata",     rdata,          32'd0);
        chk("reset_ram_en",    32'(ram_en),    32'd0);
        chk("reset_ram_we",    32'(ram_we),    32'd0);
        chk("reset_ram_addr",  32'(ram_addr),  32'd0);
        chk("reset_ram_wdata", 32'(ram_wdata), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        hold = 32'h0;
        for (int i = 0; i < vecs.size(); i++) begin
            v     = vecs[i];
            wbase = wlog.size();
            ebase = en_cnt;
            do_req(v.we, v.se, v.bs, v.addr, v.wdata, lat, e_o, rd, rdy);
            n = v.exp_err ? 0 : beats(v.bs);
            if (!v.we && !v.exp_err) hold = v.exp_rdata;
            exp_rd = hold;
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(v.exp_lat));
            chk($sformatf("v%0d_err", i), 32'(e_o), 32'(v.exp_err));
            chk($sformatf("v%0d_rdata", i), rd, exp_rd);
            chk($sformatf("v%0d_ready_in_done", i), 32'(rdy), 32'd0);
            chk($sformatf("v%0d_ram_en_cycles", i), 32'(en_cnt - ebase), 32'(n));
            if (v.we && !v.exp_err) begin
                chk($sformatf("v%0d_write_count", i), 32'(wlog.size() - wbase), 32'(n));
                for (int k = 0; k < n && (wbase + k) < wlog.size(); k++) begin
                    ea  = v.addr[11:0] + 12'(k);
                    tmp = v.wdata >> (8 * k);
                    chk($sformatf("v%0d_wr%0d_addr", i, k), 32'(wlog[wbase+k].a), 32'(ea));
                    chk($sformatf("v%0d_wr%0d_data", i, k), 32'(wlog[wbase+k].d), 32'(tmp[7:0]));
                    chk($sformatf("v%0d_wr%0d_cycle", i, k), 32'(wlog[wbase+k].cyc), 32'(k + 1));
                end
            end else begin
                chk($sformatf("v%0d_write_count", i), 32'(wlog.size() - wbase), 32'd0);
            end
        end

        // Reset in cycle 2 of a word store: only the first two bytes land.
        @(negedge clk);
        chk("rst_pre_ready", 32'(req_ready), 32'd1);
        dbase = done_cnt;
        req_valid = 1'b1; mem_we = 1'b1; mem_se = 1'b0; mem_bs = 2'b11;
        addr = 32'h0000_0040; wdata = 32'h1122_3344;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready_after", 32'(req_ready), 32'd1);
        chk("rst_ram_en_after", 32'(ram_en), 32'd0);
        chk("rst_done_after", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_no_done", 32'(done_cnt - dbase), 32'd0);
        chk("rst_mem40", 32'(tbmem[12'h040]), 32'h44);
        chk("rst_mem41", 32'(tbmem[12'h041]), 32'h33);
        chk("rst_mem42", 32'(tbmem[12'h042]), 32'hAA);
        chk("rst_mem43", 32'(tbmem[12'h043]), 32'hBB);
        do_req(1'b1, 1'b0, 2'b01, 32'h0000_0042, 32'h0000_005A, lat, e_o, rd, rdy);
        chk("post_rst_latency", 32'(lat), 32'd2);
        chk("post_rst_err", 32'(e_o), 32'd0);
        chk("post_rst_mem42", 32'(tbmem[12'h042]), 32'h5A);

        // Back-to-back byte stores with req_valid held high throughout.
        @(negedge clk);
        dbase = done_cnt;
        req_valid = 1'b1; mem_we = 1'b1; mem_se = 1'b0; mem_bs = 2'b01;
        addr = 32'h0000_0300; wdata = 32'h0000_0011;
        @(posedge clk);
        #1;
        addr  = 32'h0000_0301;
        wdata = 32'h0000_0022;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            done_bits[c-1] = done;
            rdy_bits[c-1]  = req_ready;
            if (c == 4) req_valid = 1'b0;
        end
        chk("b2b_done_pattern", 32'(done_bits), 32'b0001_0010);
        chk("b2b_ready_pattern", 32'(rdy_bits), 32'b1110_0100);
        chk("b2b_done_count", 32'(done_cnt - dbase), 32'd2);
        chk("b2b_mem300", 32'(tbmem[12'h300]), 32'h11);
        chk("b2b_mem301", 32'(tbmem[12'h301]), 32'h22);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
